// File: rtl/mips_core_pkg.sv
// Shared types for the register snapshot/recovery logic.
//   reg_image_t  : full architectural register image (NREGS words)
//   snap_state_t : recovery handshake states
//   build_capture: image as it must be stored at capture time
package mips_core_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned CKPT_DEPTH = 4;

    typedef logic [NREGS-1:0][DATA_WIDTH-1:0] reg_image_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        ACK     = 2'd2
    } snap_state_t;

    // Live image with same-cycle write-back folded in; r0 forced to zero.
    function automatic reg_image_t build_capture(
        input reg_image_t             live,
        input logic                   wb_valid,
        input logic [REG_AW-1:0]      wb_addr,
        input logic [DATA_WIDTH-1:0]  wb_data
    );
        reg_image_t img;
        img = live;
        if (wb_valid && (wb_addr != '0)) begin
            img[wb_addr] = wb_data;
        end
        img[0] = '0;
        return img;
    endfunction

endpackage

// File: rtl/snapshot_fifo.sv
// In-order checkpoint storage: DEPTH register images with head/tail/count.
//   i_push/i_push_image : store image at tail
//   i_pop               : retire head
//   i_flush             : drop every slot (overrides push/pop)
//   o_head_image        : oldest stored image
//   o_count             : number of valid slots
module snapshot_fifo
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH = CKPT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  reg_image_t             i_push_image,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output reg_image_t             o_head_image,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    reg_image_t      r_slot [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + PW'(1);
            if (i_pop)  r_head <= r_head + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Image storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_slot[r_tail] <= i_push_image;
        end
    end

    assign o_head_image = r_slot[r_head];
    assign o_count      = r_count;

endmodule

// File: rtl/reg_snapshot_ctrl.sv
// Branch checkpoint controller: captures register images at predicted
// branches, retires them on correct resolve, and on a mispredict drives
// the reg_file recover_snapshot / done / recovery_done_ack handshake.
//   ckpt_req, regs_in, wb_*           : capture side (decode / write-back)
//   resolve_valid, resolve_mispredict : EX branch outcome
//   recover_snapshot, regs_snapshot,
//   done, recovery_done_ack           : reg_file recovery handshake
//   recover_busy, ckpt_full,
//   ckpt_count, err                   : status
module reg_snapshot_ctrl
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH = CKPT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ckpt_req,
    output logic                   ckpt_full,
    input  reg_image_t             regs_in,
    input  logic                   wb_uses_rw,
    input  logic [REG_AW-1:0]      wb_rw_addr,
    input  logic [DATA_WIDTH-1:0]  wb_rw_data,
    input  logic                   resolve_valid,
    input  logic                   resolve_mispredict,
    output logic                   recover_snapshot,
    output reg_image_t             regs_snapshot,
    input  logic                   done,
    output logic                   recovery_done_ack,
    output logic                   recover_busy,
    output logic [$clog2(DEPTH):0] ckpt_count,
    output logic                   err
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    snap_state_t r_state;
    snap_state_t w_next_state;
    logic        w_idle;
    logic        w_empty;
    logic        w_any_misp;
    logic        w_mispredict;
    logic        w_pop;
    logic        w_push;
    logic        w_err_set;
    logic        w_rs_next;
    logic        w_ack_next;
    logic        w_busy_next;
    reg_image_t  w_head_image;
    reg_image_t  w_capture_image;

    assign w_idle     = (r_state == IDLE);
    assign w_empty    = (ckpt_count == '0);
    assign ckpt_full  = (ckpt_count == CW'(DEPTH));
    assign w_any_misp = resolve_valid && resolve_mispredict;

    assign w_mispredict = w_idle && w_any_misp && !w_empty;
    assign w_pop        = w_idle && resolve_valid && !resolve_mispredict && !w_empty;
    // A correct resolve frees the head slot, so capture is legal even when full.
    assign w_push       = w_idle && ckpt_req && !w_any_misp && (!ckpt_full || w_pop);
    assign w_err_set    = w_idle && ((resolve_valid && w_empty) ||
                                     (ckpt_req && ckpt_full && !resolve_valid));

    assign w_capture_image = build_capture(regs_in, wb_uses_rw, wb_rw_addr, wb_rw_data);

    snapshot_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_image (w_capture_image),
        .i_pop        (w_pop),
        .i_flush      (w_mispredict),
        .o_head_image (w_head_image),
        .o_count      (ckpt_count)
    );

    // State register with registered Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= IDLE;
            recover_snapshot  <= 1'b0;
            recovery_done_ack <= 1'b0;
            recover_busy      <= 1'b0;
        end else begin
            r_state           <= w_next_state;
            recover_snapshot  <= w_rs_next;
            recovery_done_ack <= w_ack_next;
            recover_busy      <= w_busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_mispredict) w_next_state = RECOVER;
            RECOVER: if (done)         w_next_state = ACK;
            ACK:     if (!done)        w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output decode of the next state, registered above.
    always_comb begin
        w_rs_next   = 1'b0;
        w_ack_next  = 1'b0;
        w_busy_next = 1'b0;
        case (w_next_state)
            RECOVER: begin
                w_rs_next   = 1'b1;
                w_busy_next = 1'b1;
            end
            ACK: begin
                w_ack_next  = 1'b1;
                w_busy_next = 1'b1;
            end
            default: ;
        endcase
    end

    // Restored image holds until the next mispredict; err is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_snapshot <= '0;
            err           <= 1'b0;
        end else begin
            if (w_mispredict) regs_snapshot <= w_head_image;
            if (w_err_set)    err           <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_snapshot_ctrl.sv
module tb_reg_snapshot_ctrl;
    import mips_core_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   ckpt_req = 1'b0;
    logic                   ckpt_full;
    reg_image_t             regs_in = '0;
    logic                   wb_uses_rw = 1'b0;
    logic [REG_AW-1:0]      wb_rw_addr = '0;
    logic [DATA_WIDTH-1:0]  wb_rw_data = '0;
    logic                   resolve_valid = 1'b0;
    logic                   resolve_mispredict = 1'b0;
    logic                   recover_snapshot;
    reg_image_t             regs_snapshot;
    logic                   done = 1'b0;
    logic                   recovery_done_ack;
    logic                   recover_busy;
    logic [$clog2(DEPTH):0] ckpt_count;
    logic                   err;

    int total = 0;
    int bad = 0;
    bit auto_done = 1'b1;
    reg_image_t q[$];

    reg_snapshot_ctrl #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst                (rst),
        .ckpt_req           (ckpt_req),
        .ckpt_full          (ckpt_full),
        .regs_in            (regs_in),
        .wb_uses_rw         (wb_uses_rw),
        .wb_rw_addr         (wb_rw_addr),
        .wb_rw_data         (wb_rw_data),
        .resolve_valid      (resolve_valid),
        .resolve_mispredict (resolve_mispredict),
        .recover_snapshot   (recover_snapshot),
        .regs_snapshot      (regs_snapshot),
        .done               (done),
        .recovery_done_ack  (recovery_done_ack),
        .recover_busy       (recover_busy),
        .ckpt_count         (ckpt_count),
        .err                (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_img(input string tag, input reg_image_t got, input reg_image_t exp);
        for (int i = 0; i < NREGS; i++) begin
            chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
        end
    endtask

    // One clock; the reg_file model reacts to outputs seen at the edge.
    task automatic cycle();
        logic s_rs, s_ack;
        s_rs  = recover_snapshot;
        s_ack = recovery_done_ack;
        @(posedge clk);
        #1;
        if (auto_done) begin
            if (s_ack)     done = 1'b0;
            else if (s_rs) done = 1'b1;
        end
    endtask

    function automatic reg_image_t rand_img();
        reg_image_t r;
        for (int i = 0; i < NREGS; i++) r[i] = $urandom;
        return r;
    endfunction

    function automatic reg_image_t expect_img(input reg_image_t img, input logic wb,
                                              input logic [REG_AW-1:0] a,
                                              input logic [DATA_WIDTH-1:0] d);
        reg_image_t e;
        e = img;
        if (wb && a != 0) e[a] = d;
        e[0] = 32'h0;
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        done = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle();
    endtask

    task automatic capture(input reg_image_t img, input logic wb,
                           input logic [REG_AW-1:0] a, input logic [DATA_WIDTH-1:0] d);
        regs_in    = img;
        wb_uses_rw = wb;
        wb_rw_addr = a;
        wb_rw_data = d;
        ckpt_req   = 1'b1;
        if (q.size() < DEPTH) q.push_back(expect_img(img, wb, a, d));
        cycle();
        ckpt_req   = 1'b0;
        wb_uses_rw = 1'b0;
    endtask

    // Mispredict with auto reg_file; optional poke of ckpt_req/resolve while busy.
    task automatic mispredict_run(input string tag, input bit poke);
        reg_image_t e;
        int n;
        e = '0;
        if (q.size() != 0) e = q[0];
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        cycle();
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        q.delete();
        chk({tag, "_rs"}, 64'(recover_snapshot), 64'd1);
        chk_img({tag, "_img"}, regs_snapshot, e);
        chk({tag, "_cnt"}, 64'(ckpt_count), 64'd0);
        n = 1;
        while (recover_busy && n < 20) begin
            if (poke && n == 1) begin
                ckpt_req = 1'b1;
                regs_in = rand_img();
            end
            cycle();
            ckpt_req = 1'b0;
            if (poke && n == 1) begin
                chk({tag, "_poke_cnt"}, 64'(ckpt_count), 64'd0);
                chk({tag, "_poke_err"}, 64'(err), 64'd0);
            end
            n++;
        end
        chk({tag, "_busy_cycles"}, 64'(n - 1), 64'd4);
        chk({tag, "_idle"}, 64'(recover_busy), 64'd0);
        chk({tag, "_ack_end"}, 64'(recovery_done_ack), 64'd0);
        chk({tag, "_cnt_end"}, 64'(ckpt_count), 64'd0);
        chk_img({tag, "_hold"}, regs_snapshot, e);
    endtask

    initial begin
        reg_image_t img, i1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("rst_cnt", 64'(ckpt_count), 64'd0);
        chk("rst_full", 64'(ckpt_full), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rs", 64'(recover_snapshot), 64'd0);
        chk("rst_ack", 64'(recovery_done_ack), 64'd0);
        chk("rst_busy", 64'(recover_busy), 64'd0);
        chk("rst_snap", 64'(|regs_snapshot), 64'd0);

        // Capture then correct resolve.
        img = rand_img();
        img[5] = 32'h1111_0005;
        capture(img, 1'b0, 5'd0, 32'h0);
        chk("t1_cnt1", 64'(ckpt_count), 64'd1);
        resolve_valid = 1'b1;
        cycle();
        resolve_valid = 1'b0;
        void'(q.pop_front());
        chk("t1_cnt0", 64'(ckpt_count), 64'd0);
        chk("t1_rs", 64'(recover_snapshot), 64'd0);
        chk("t1_err", 64'(err), 64'd0);

        // Mispredict restore with same-cycle write-back bypass; r0 forced zero.
        img = rand_img();
        img[3] = 32'hA;
        img[0] = 32'hDEAD_BEEF;
        capture(img, 1'b1, 5'd3, 32'hB);
        chk("t2_snap_pre", 64'(recover_snapshot), 64'd0);
        chk("t2_r3_model", 64'(q[0][3]), 64'hB);
        mispredict_run("t2", 1'b0);
        chk("t2_r3", 64'(regs_snapshot[3]), 64'hB);
        chk("t2_r0", 64'(regs_snapshot[0]), 64'h0);
        chk("t2_err", 64'(err), 64'd0);

        // Full, overflow error, capture+pop while full, wrap.
        for (int k = 0; k < 4; k++) begin
            img = rand_img();
            if (k == 1) i1 = expect_img(img, 1'b0, 5'd0, 32'h0);
            capture(img, 1'b0, 5'd0, 32'h0);
        end
        chk("t3_full", 64'(ckpt_full), 64'd1);
        chk("t3_cnt4", 64'(ckpt_count), 64'd4);
        chk("t3_err0", 64'(err), 64'd0);
        capture(rand_img(), 1'b0, 5'd0, 32'h0);
        chk("t3_ovf_err", 64'(err), 64'd1);
        chk("t3_ovf_cnt", 64'(ckpt_count), 64'd4);
        img = rand_img();
        regs_in = img;
        ckpt_req = 1'b1;
        resolve_valid = 1'b1;
        void'(q.pop_front());
        q.push_back(expect_img(img, 1'b0, 5'd0, 32'h0));
        cycle();
        ckpt_req = 1'b0;
        resolve_valid = 1'b0;
        chk("t3_both_cnt", 64'(ckpt_count), 64'd4);
        chk("t3_both_full", 64'(ckpt_full), 64'd1);
        mispredict_run("t3", 1'b0);
        chk_img("t3_second", regs_snapshot, i1);
        chk("t3_err_sticky", 64'(err), 64'd1);

        // Flush of younger checkpoints; requests during busy ignored.
        do_reset();
        chk("t4_err_rst", 64'(err), 64'd0);
        for (int k = 0; k < 3; k++) capture(rand_img(), 1'b0, 5'd0, 32'h0);
        chk("t4_cnt3", 64'(ckpt_count), 64'd3);
        mispredict_run("t4", 1'b1);
        chk("t4_err", 64'(err), 64'd0);

        // Resolve with nothing outstanding sets err.
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        cycle();
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        chk("t5_misp_empty_busy", 64'(recover_busy), 64'd0);
        chk("t5_misp_empty_err", 64'(err), 64'd1);
        do_reset();

        // Slow done handshake driven by hand.
        auto_done = 1'b0;
        capture(rand_img(), 1'b0, 5'd0, 32'h0);
        img = q[0];
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        cycle();
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        q.delete();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t6_rs_%0d", k), 64'(recover_snapshot), 64'd1);
            chk($sformatf("t6_ack_%0d", k), 64'(recovery_done_ack), 64'd0);
            cycle();
        end
        done = 1'b1;
        cycle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_ackhold_%0d", k), 64'(recovery_done_ack), 64'd1);
            chk($sformatf("t6_rslow_%0d", k), 64'(recover_snapshot), 64'd0);
            if (k < 2) cycle();
        end
        done = 1'b0;
        cycle();
        chk("t6_ack_end", 64'(recovery_done_ack), 64'd0);
        chk("t6_busy_end", 64'(recover_busy), 64'd0);
        chk_img("t6_img", regs_snapshot, img);

        // Asynchronous reset while in ACK.
        resolve_valid = 1'b1;
        cycle();
        resolve_valid = 1'b0;
        chk("t7_err_pre", 64'(err), 64'd1);
        capture(rand_img(), 1'b0, 5'd0, 32'h0);
        capture(rand_img(), 1'b0, 5'd0, 32'h0);
        resolve_valid = 1'b1;
        resolve_mispredict = 1'b1;
        cycle();
        resolve_valid = 1'b0;
        resolve_mispredict = 1'b0;
        q.delete();
        done = 1'b1;
        cycle();
        chk("t7_in_ack", 64'(recovery_done_ack), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t7_rs", 64'(recover_snapshot), 64'd0);
        chk("t7_ack", 64'(recovery_done_ack), 64'd0);
        chk("t7_busy", 64'(recover_busy), 64'd0);
        chk("t7_cnt", 64'(ckpt_count), 64'd0);
        chk("t7_err", 64'(err), 64'd0);
        chk("t7_snap", 64'(|regs_snapshot), 64'd0);
        done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("t7_idle_after", 64'(recover_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_snapshot_ctrl.md
Name: reg_snapshot_ctrl

Overview:
- Initiator side of the register-file snapshot/recovery handshake.
- Captures a full 32-entry architectural register image at each predicted branch and keeps the images in a small in-order checkpoint FIFO.
- Pops an image when its branch resolves correctly.
- On a mispredict, drives the register file's recover_snapshot / done / recovery_done_ack protocol to restore the image, then flushes all younger checkpoints.
- Sits beside reg_file, fed by decode (checkpoint request), EX (branch resolve) and write-back.

Parameters:
- DEPTH, 4, number of checkpoint slots; power of two, 2..8.
- NREGS, 32, registers per image; fixed by the ISA.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ckpt_req  in  1  decode has a predicted branch; capture the image this cycle
- ckpt_full  out  1  all DEPTH slots valid; decode must stall branches
- regs_in  in  32x`DATA_WIDTH  live register image (reg_file regs_out)
- wb_uses_rw  in  1  write-back valid this cycle
- wb_rw_addr  in  5  write-back register address
- wb_rw_data  in  `DATA_WIDTH  write-back data
- resolve_valid  in  1  oldest outstanding branch resolved
- resolve_mispredict  in  1  qualifies resolve_valid; 1 = mispredicted
- recover_snapshot  out  1  to reg_file; level request
- regs_snapshot  out  32x`DATA_WIDTH  to reg_file; image being restored
- done  in  1  from reg_file
- recovery_done_ack  out  1  to reg_file
- recover_busy  out  1  recovery in progress; pipeline must stall
- ckpt_count  out  $clog2(DEPTH)+1  number of valid slots
- err  out  1  sticky protocol error

Behaviour:
- Reset: all slots invalid; head = tail = 0; state IDLE; all outputs 0, including regs_snapshot.
- Contract: ckpt_req is asserted only when every instruction older than the branch has written back or writes back in the same cycle. Branches resolve in program order.

Capture:
- On ckpt_req && !ckpt_full && state==IDLE && !(resolve_valid && resolve_mispredict), store regs_in into slot[tail], then tail++ (wraps modulo DEPTH).
- Same-cycle write-back bypass: if wb_uses_rw && wb_rw_addr!=0, the stored entry [wb_rw_addr] = wb_rw_data.
- Register 0 is always stored as 0.

Resolve:
- resolve_valid && !mispredict: pop head (head++, wraps).
- Capture and correct resolve in the same cycle: both take effect. This holds when full, so the count stays at DEPTH.
- resolve_valid with count==0: ignored, err set.
- ckpt_req while full: ignored, err set.

Mispredict (resolve_valid && mispredict, state IDLE, count>0):
- Latch slot[head] into the regs_snapshot register.
- Invalidate all slots; head = tail = 0.
- Drop any same-cycle ckpt_req.
- Go to RECOVER.
- Mispredict with count==0: ignored, err set.

FSM (Moore, registered outputs):
- IDLE: recover_snapshot=0, ack=0.
- RECOVER: recover_snapshot=1; leave to ACK when done==1.
- ACK: recover_snapshot=0, recovery_done_ack=1; leave to IDLE when done==0.
- recover_busy = (state != IDLE).
- While busy, resolve_valid and ckpt_req are ignored without setting err.
- regs_snapshot holds its value from entering RECOVER until the next mispredict.

Timing against reg_file (mispredict sampled at edge E0):
- recover_snapshot=1 after E0.
- done=1 after E1.
- ack=1, recover_snapshot=0 after E2.
- done=0 after E3.
- IDLE after E4.
- Minimum total: 4 busy cycles.

Reset mid-recovery: returns immediately to IDLE with all outputs 0. The reg_file done flag is not cleared by this block.

Outputs:
- ckpt_full = (count == DEPTH), combinational from count.
- err clears only on rst.

Decomposition:
- Put in mips_core_pkg:
  - typedef reg_image_t (array of NREGS `DATA_WIDTH words)
  - enum snap_state_t {IDLE, RECOVER, ACK}
  - localparam CKPT_DEPTH
- One sub-module, snapshot_fifo: slot storage, head/tail/count, capture with wb bypass, pop, flush.
- The FSM and error logic stay in the top.

Test Plan:
- Capture then correct resolve: regs_in[5]=32'h1111_0005, ckpt_req -> count=1; resolve_valid, mispredict=0 -> count=0, no recover_snapshot, err=0.
- Mispredict restore with bypass: regs_in[3]=32'hA, same-cycle wb r3=32'hB with ckpt_req; later mispredict -> recover_snapshot high next cycle, regs_snapshot[3]=32'hB; with reg_file model, done/ack sequence completes in 4 busy cycles; count=0 afterward.
- Full/wrap: 4 captures -> ckpt_full=1; 5th ckpt_req -> err=1, count=4; capture plus correct resolve same cycle while full -> count=4, tail wraps to 0, next popped image is the 2nd captured one.
- Flush of younger checkpoints: 3 captures of images I0, I1, I2; mispredict -> regs_snapshot=I0, count=0; ckpt_req during busy ignored, err unchanged.
- Slow done: hold done=0 for 10 cycles in RECOVER -> recover_snapshot stays 1, ack=0; done=1 -> ack next cycle; done held 1 for 3 cycles -> ack held until done=0.
- Async reset in ACK state: rst asserted mid-cycle -> recover_snapshot, ack, busy, count, err all 0 immediately, without waiting for a clock edge.
